// File: rtl/cu.sv
// Main control unit for a single-cycle MIPS-style CPU.
// Decodes op/func into datapath controls and resolves branches from the ALU
// zero flag. A start-up bit keeps architectural side effects (register and
// memory writes, PC redirection) off during and just after reset.
module cu (
    input  logic       clk,
    input  logic       rst_n,      // active-high synchronous reset despite the name
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [4:0] ALUControl,
    output logic [1:0] Branch,
    output logic       ALUSrcA,
    output logic       ALuSrcB,
    output logic [4:0] RegDst,
    output logic       Extend,
    output logic       PCtoReg
);

    // ALU operation codes
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_NOR  = 5'b00101;
    localparam logic [4:0] ALU_SLT  = 5'b00110;
    localparam logic [4:0] ALU_SLTU = 5'b00111;
    localparam logic [4:0] ALU_SLL  = 5'b01000;
    localparam logic [4:0] ALU_SRL  = 5'b01001;
    localparam logic [4:0] ALU_SRA  = 5'b01010;
    localparam logic [4:0] ALU_LUI  = 5'b01011;

    // One-hot destination register selects
    localparam logic [4:0] DST_NONE = 5'b00000;
    localparam logic [4:0] DST_RT   = 5'b00001;
    localparam logic [4:0] DST_RD   = 5'b00010;
    localparam logic [4:0] DST_RA   = 5'b00100;

    // Next-PC selects
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] PC_REG  = 2'b11;

    logic       run_q;
    logic       run_d;
    logic       gate;

    logic       dec_memtoreg;
    logic       dec_memwrite;
    logic       dec_regwrite;
    logic [4:0] dec_aluctl;
    logic [1:0] dec_branch;
    logic       dec_srca;
    logic       dec_srcb;
    logic [4:0] dec_regdst;
    logic       dec_extend;
    logic       dec_pctoreg;

    // Start-up bit: cleared while reset is sampled high, set on the first edge without it
    assign run_d = ~rst_n;

    // Start-up register update
    always_ff @(posedge clk) begin
        if (rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    // Instruction decode; only the branch select looks at zero so the
    // ALU -> zero -> ALUControl path never forms a combinational loop
    always_comb begin
        dec_memtoreg = 1'b0;
        dec_memwrite = 1'b0;
        dec_regwrite = 1'b0;
        dec_aluctl   = ALU_ADD;
        dec_branch   = PC_SEQ;
        dec_srca     = 1'b0;
        dec_srcb     = 1'b0;
        dec_regdst   = DST_NONE;
        dec_extend   = 1'b0;
        dec_pctoreg  = 1'b0;

        case (op)
            6'b000000: begin
                // R-type: most functions write rd; unknown func stays a NOP
                dec_regwrite = 1'b1;
                dec_regdst   = DST_RD;
                case (func)
                    6'b100000, 6'b100001: dec_aluctl = ALU_ADD;
                    6'b100010, 6'b100011: dec_aluctl = ALU_SUB;
                    6'b100100: dec_aluctl = ALU_AND;
                    6'b100101: dec_aluctl = ALU_OR;
                    6'b100110: dec_aluctl = ALU_XOR;
                    6'b100111: dec_aluctl = ALU_NOR;
                    6'b101010: dec_aluctl = ALU_SLT;
                    6'b101011: dec_aluctl = ALU_SLTU;
                    6'b000000: begin dec_aluctl = ALU_SLL; dec_srca = 1'b1; end
                    6'b000010: begin dec_aluctl = ALU_SRL; dec_srca = 1'b1; end
                    6'b000011: begin dec_aluctl = ALU_SRA; dec_srca = 1'b1; end
                    6'b000100: dec_aluctl = ALU_SLL;
                    6'b000110: dec_aluctl = ALU_SRL;
                    6'b000111: dec_aluctl = ALU_SRA;
                    6'b001000: begin
                        dec_branch   = PC_REG;
                        dec_regwrite = 1'b0;
                        dec_regdst   = DST_NONE;
                    end
                    6'b001001: begin
                        dec_branch  = PC_REG;
                        dec_pctoreg = 1'b1;
                    end
                    default: begin
                        dec_regwrite = 1'b0;
                        dec_regdst   = DST_NONE;
                    end
                endcase
            end
            6'b001000, 6'b001001: begin
                dec_aluctl = ALU_ADD; dec_extend = 1'b1;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b001010: begin
                dec_aluctl = ALU_SLT; dec_extend = 1'b1;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b001011: begin
                dec_aluctl = ALU_SLTU; dec_extend = 1'b1;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b001100: begin
                dec_aluctl = ALU_AND;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b001101: begin
                dec_aluctl = ALU_OR;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b001110: begin
                dec_aluctl = ALU_XOR;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b001111: begin
                dec_aluctl = ALU_LUI;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b100011: begin
                dec_aluctl = ALU_ADD; dec_extend = 1'b1; dec_memtoreg = 1'b1;
                dec_srcb = 1'b1; dec_regwrite = 1'b1; dec_regdst = DST_RT;
            end
            6'b101011: begin
                dec_aluctl = ALU_ADD; dec_extend = 1'b1;
                dec_srcb = 1'b1; dec_memwrite = 1'b1;
            end
            6'b000100: begin
                dec_aluctl = ALU_SUB; dec_extend = 1'b1;
                if (zero) dec_branch = PC_BR;
            end
            6'b000101: begin
                dec_aluctl = ALU_SUB; dec_extend = 1'b1;
                if (!zero) dec_branch = PC_BR;
            end
            6'b000010: dec_branch = PC_JMP;
            6'b000011: begin
                dec_branch   = PC_JMP;
                dec_regwrite = 1'b1;
                dec_regdst   = DST_RA;
                dec_pctoreg  = 1'b1;
            end
            default: ;
        endcase
    end

    // Side effects are suppressed while reset is high or before the first running edge
    assign gate = rst_n | ~run_q;

    assign MemtoReg   = dec_memtoreg & ~gate;
    assign MemWrite   = dec_memwrite & ~gate;
    assign RegWrite   = dec_regwrite & ~gate;
    assign Branch     = gate ? PC_SEQ : dec_branch;
    assign PCtoReg    = dec_pctoreg & ~gate;
    assign ALUControl = dec_aluctl;
    assign ALUSrcA    = dec_srca;
    assign ALuSrcB    = dec_srcb;
    assign RegDst     = dec_regdst;
    assign Extend     = dec_extend;

endmodule

// File: tb/tb_cu.sv
// Self-checking bench for the control unit: expected control vectors are
// queued when an instruction is driven and compared once outputs settle.
module tb_cu;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       MemtoReg;
    logic       MemWrite;
    logic       RegWrite;
    logic [4:0] ALUControl;
    logic [1:0] Branch;
    logic       ALUSrcA;
    logic       ALuSrcB;
    logic [4:0] RegDst;
    logic       Extend;
    logic       PCtoReg;

    int checks = 0;
    int fails  = 0;

    logic [18:0] sb[$];
    logic [18:0] expv;
    logic [18:0] obs;

    typedef struct {
        logic        rst;
        logic        new_cycle;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic [18:0] exp;
        string       name;
    } vec_t;

    cu dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .Branch(Branch), .ALUSrcA(ALUSrcA),
        .ALuSrcB(ALuSrcB), .RegDst(RegDst), .Extend(Extend), .PCtoReg(PCtoReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack fields: MemtoReg MemWrite RegWrite ALUControl Branch ALUSrcA ALuSrcB RegDst Extend PCtoReg
    function automatic logic [18:0] mk(input logic mtr, input logic mw, input logic rw,
                                       input logic [4:0] alu, input logic [1:0] br,
                                       input logic sa, input logic sbb, input logic [4:0] rd,
                                       input logic ex, input logic pc);
        return {mtr, mw, rw, alu, br, sa, sbb, rd, ex, pc};
    endfunction

    function automatic logic [18:0] observed();
        return {MemtoReg, MemWrite, RegWrite, ALUControl, Branch, ALUSrcA, ALuSrcB,
                RegDst, Extend, PCtoReg};
    endfunction

    function automatic vec_t v(input logic rst, input logic nc, input logic [5:0] o,
                               input logic [5:0] f, input logic z, input logic [18:0] e,
                               input string n);
        vec_t t;
        t.rst = rst; t.new_cycle = nc; t.op = o; t.func = f; t.zero = z; t.exp = e; t.name = n;
        return t;
    endfunction

    // Drive one stimulus entry and queue its expected result
    task automatic drive(input vec_t t);
        if (t.new_cycle) @(negedge clk);
        rst_n = t.rst; op = t.op; func = t.func; zero = t.zero;
        sb.push_back(t.exp);
        #2;
    endtask

    task automatic test_reset();
        vec_t tv[$];
        // lw held through reset: side effects gated until one edge after release
        tv.push_back(v(1'b1, 1'b1, 6'b100011, 6'b0, 1'b0, mk(0,0,0,5'd0,2'd0,0,1,5'd1,1,0), "rst_cyc1"));
        tv.push_back(v(1'b1, 1'b1, 6'b100011, 6'b0, 1'b0, mk(0,0,0,5'd0,2'd0,0,1,5'd1,1,0), "rst_cyc2"));
        tv.push_back(v(1'b0, 1'b0, 6'b100011, 6'b0, 1'b0, mk(0,0,0,5'd0,2'd0,0,1,5'd1,1,0), "rel_cyc1"));
        tv.push_back(v(1'b0, 1'b1, 6'b100011, 6'b0, 1'b0, mk(1,0,1,5'd0,2'd0,0,1,5'd1,1,0), "lw_run"));
        foreach (tv[i]) begin
            drive(tv[i]);
            expv = sb.pop_front(); obs = observed(); checks++;
            $display("txn %-10s rst=%b op=%b func=%b zero=%b out=%b", tv[i].name, rst_n, op, func, zero, obs);
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s: got %b expected %b", tv[i].name, obs, expv);
            end
        end
    endtask

    task automatic test_rtype();
        vec_t tv[$];
        tv.push_back(v(0,1,6'd0,6'b100010,0, mk(0,0,1,5'd1, 2'd0,0,0,5'd2,0,0), "sub"));
        tv.push_back(v(0,1,6'd0,6'b000011,0, mk(0,0,1,5'd10,2'd0,1,0,5'd2,0,0), "sra"));
        tv.push_back(v(0,1,6'd0,6'b000111,1, mk(0,0,1,5'd10,2'd0,0,0,5'd2,0,0), "srav"));
        tv.push_back(v(0,1,6'd0,6'b000100,0, mk(0,0,1,5'd8, 2'd0,0,0,5'd2,0,0), "sllv"));
        tv.push_back(v(0,1,6'd0,6'b100100,0, mk(0,0,1,5'd2, 2'd0,0,0,5'd2,0,0), "and"));
        tv.push_back(v(0,1,6'd0,6'b100111,0, mk(0,0,1,5'd5, 2'd0,0,0,5'd2,0,0), "nor"));
        tv.push_back(v(0,1,6'd0,6'b101011,0, mk(0,0,1,5'd7, 2'd0,0,0,5'd2,0,0), "sltu"));
        tv.push_back(v(0,1,6'd0,6'b000010,0, mk(0,0,1,5'd9, 2'd0,1,0,5'd2,0,0), "srl"));
        foreach (tv[i]) begin
            drive(tv[i]);
            expv = sb.pop_front(); obs = observed(); checks++;
            $display("txn %-10s rst=%b op=%b func=%b zero=%b out=%b", tv[i].name, rst_n, op, func, zero, obs);
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s: got %b expected %b", tv[i].name, obs, expv);
            end
        end
    endtask

    task automatic test_branch();
        vec_t tv[$];
        tv.push_back(v(0,1,6'b000100,6'd0,1, mk(0,0,0,5'd1,2'd1,0,0,5'd0,1,0), "beq_z1"));
        tv.push_back(v(0,1,6'b000100,6'd0,0, mk(0,0,0,5'd1,2'd0,0,0,5'd0,1,0), "beq_z0"));
        tv.push_back(v(0,1,6'b000101,6'd0,1, mk(0,0,0,5'd1,2'd0,0,0,5'd0,1,0), "bne_z1"));
        tv.push_back(v(0,1,6'b000101,6'd0,0, mk(0,0,0,5'd1,2'd1,0,0,5'd0,1,0), "bne_z0"));
        foreach (tv[i]) begin
            drive(tv[i]);
            expv = sb.pop_front(); obs = observed(); checks++;
            $display("txn %-10s rst=%b op=%b func=%b zero=%b out=%b", tv[i].name, rst_n, op, func, zero, obs);
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s: got %b expected %b", tv[i].name, obs, expv);
            end
        end
    endtask

    task automatic test_jumps();
        vec_t tv[$];
        tv.push_back(v(0,1,6'b000011,6'd0,     0, mk(0,0,1,5'd0,2'd2,0,0,5'd4,0,1), "jal"));
        tv.push_back(v(0,1,6'b000010,6'd0,     1, mk(0,0,0,5'd0,2'd2,0,0,5'd0,0,0), "j"));
        tv.push_back(v(0,1,6'd0,     6'b001000,0, mk(0,0,0,5'd0,2'd3,0,0,5'd0,0,0), "jr"));
        tv.push_back(v(0,1,6'd0,     6'b001001,1, mk(0,0,1,5'd0,2'd3,0,0,5'd2,0,1), "jalr"));
        foreach (tv[i]) begin
            drive(tv[i]);
            expv = sb.pop_front(); obs = observed(); checks++;
            $display("txn %-10s rst=%b op=%b func=%b zero=%b out=%b", tv[i].name, rst_n, op, func, zero, obs);
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s: got %b expected %b", tv[i].name, obs, expv);
            end
        end
    endtask

    task automatic test_itype();
        vec_t tv[$];
        tv.push_back(v(0,1,6'b101011,6'd0,0, mk(0,1,0,5'd0, 2'd0,0,1,5'd0,1,0), "sw"));
        tv.push_back(v(0,1,6'b001101,6'd0,0, mk(0,0,1,5'd3, 2'd0,0,1,5'd1,0,0), "ori"));
        tv.push_back(v(0,1,6'b001111,6'd0,0, mk(0,0,1,5'd11,2'd0,0,1,5'd1,0,0), "lui"));
        tv.push_back(v(0,1,6'b001001,6'd0,1, mk(0,0,1,5'd0, 2'd0,0,1,5'd1,1,0), "addiu"));
        tv.push_back(v(0,1,6'b001011,6'd0,0, mk(0,0,1,5'd7, 2'd0,0,1,5'd1,1,0), "sltiu"));
        tv.push_back(v(0,1,6'b001110,6'd0,0, mk(0,0,1,5'd4, 2'd0,0,1,5'd1,0,0), "xori"));
        tv.push_back(v(0,1,6'b001100,6'd0,0, mk(0,0,1,5'd2, 2'd0,0,1,5'd1,0,0), "andi"));
        foreach (tv[i]) begin
            drive(tv[i]);
            expv = sb.pop_front(); obs = observed(); checks++;
            $display("txn %-10s rst=%b op=%b func=%b zero=%b out=%b", tv[i].name, rst_n, op, func, zero, obs);
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s: got %b expected %b", tv[i].name, obs, expv);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t tv[$];
        tv.push_back(v(0,1,6'b111111,6'd0,     1, 19'd0, "op_111111"));
        tv.push_back(v(0,1,6'd0,     6'b111111,0, 19'd0, "func_111111"));
        tv.push_back(v(0,1,6'b000001,6'b100000,1, 19'd0, "op_000001"));
        foreach (tv[i]) begin
            drive(tv[i]);
            expv = sb.pop_front(); obs = observed(); checks++;
            $display("txn %-10s rst=%b op=%b func=%b zero=%b out=%b", tv[i].name, rst_n, op, func, zero, obs);
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s: got %b expected %b", tv[i].name, obs, expv);
            end
        end
    endtask

    task automatic test_reset_during_sw();
        vec_t tv[$];
        // Mid-run reset gates in the same cycle; decoded selects keep their sw values
        tv.push_back(v(0,1,6'b101011,6'd0,0, mk(0,1,0,5'd0,2'd0,0,1,5'd0,1,0), "sw_run"));
        tv.push_back(v(1,0,6'b101011,6'd0,0, mk(0,0,0,5'd0,2'd0,0,1,5'd0,1,0), "sw_rst_now"));
        tv.push_back(v(1,1,6'b101011,6'd0,0, mk(0,0,0,5'd0,2'd0,0,1,5'd0,1,0), "sw_rst_hold"));
        tv.push_back(v(0,1,6'b101011,6'd0,0, mk(0,0,0,5'd0,2'd0,0,1,5'd0,1,0), "sw_rel1"));
        tv.push_back(v(0,1,6'b101011,6'd0,0, mk(0,1,0,5'd0,2'd0,0,1,5'd0,1,0), "sw_rerun"));
        foreach (tv[i]) begin
            drive(tv[i]);
            expv = sb.pop_front(); obs = observed(); checks++;
            $display("txn %-10s rst=%b op=%b func=%b zero=%b out=%b", tv[i].name, rst_n, op, func, zero, obs);
            if (obs !== expv) begin
                fails++;
                $display("FAIL %s: got %b expected %b", tv[i].name, obs, expv);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        op    = 6'b100011;
        func  = 6'd0;
        zero  = 1'b0;
        test_reset();
        test_rtype();
        test_branch();
        test_jumps();
        test_itype();
        test_illegal();
        test_reset_during_sw();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
